// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO that decouples instruction fetch from decode.
// Each entry carries {pc, pc_p4, instr, pred_taken, pred_target} (129 bits).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush_i                     redirect; drops every queued entry at the next edge
//   f_valid_i / f_ready_o       fetch-side handshake (f_ready_o = not full)
//   f_pc_i .. f_pred_target_i   fetch-side entry fields
//   d_valid_o / d_ready_i       decode-side handshake for the head entry
//   d_pc_o .. d_pred_target_o   head-entry fields, zero when d_valid_o is low
//   count_o                     current occupancy, 0..DEPTH
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     f_valid_i,
  output logic                     f_ready_o,
  input  logic [31:0]              f_pc_i,
  input  logic [31:0]              f_pc_p4_i,
  input  logic [31:0]              f_instr_i,
  input  logic                     f_pred_taken_i,
  input  logic [31:0]              f_pred_target_i,
  output logic                     d_valid_o,
  input  logic                     d_ready_i,
  output logic [31:0]              d_pc_o,
  output logic [31:0]              d_pc_p4_o,
  output logic [31:0]              d_instr_o,
  output logic                     d_pred_taken_o,
  output logic [31:0]              d_pred_target_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 129;

  logic [EntW-1:0] r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [EntW-1:0] w_wr_data;
  logic [EntW-1:0] w_head;

  // Explicit wrap keeps the pointer correct even if a non power-of-two depth is used.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Readiness is purely occupancy based, so a full queue never pushes alongside a pop.
  assign f_ready_o = !w_full;
  assign d_valid_o = !w_empty && !flush_i;

  assign w_push = f_valid_i && f_ready_o && !flush_i;
  assign w_pop  = d_valid_o && d_ready_i;

  assign w_wr_data = {f_pc_i, f_pc_p4_i, f_instr_i, f_pred_taken_i, f_pred_target_i};
  assign w_head    = r_mem[r_rd_ptr];

  // Head is read only from storage; no path from f_* to d_* exists.
  always_comb begin
    {d_pc_o, d_pc_p4_o, d_instr_o, d_pred_taken_o, d_pred_target_o} = '0;
    if (d_valid_o) begin
      {d_pc_o, d_pc_p4_o, d_instr_o, d_pred_taken_o, d_pred_target_o} = w_head;
    end
  end

  assign count_o = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not cleared by flush; the d_* gating hides stale entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_p4;
    logic [31:0] instr;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic        flush;
    logic        fv;
    logic [31:0] pc;
    logic        dr;
    int          cnt;
    logic        frdy;
    logic        dv;
    logic [31:0] dpc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        f_valid_i = 1'b0;
  logic        f_ready_o;
  logic [31:0] f_pc_i = '0;
  logic [31:0] f_pc_p4_i = '0;
  logic [31:0] f_instr_i = '0;
  logic        f_pred_taken_i = 1'b0;
  logic [31:0] f_pred_target_i = '0;
  logic        d_valid_o;
  logic        d_ready_i = 1'b0;
  logic [31:0] d_pc_o;
  logic [31:0] d_pc_p4_o;
  logic [31:0] d_instr_o;
  logic        d_pred_taken_o;
  logic [31:0] d_pred_target_o;
  logic [$clog2(DEPTH):0] count_o;

  int n_tests = 0;
  int n_fail  = 0;
  ent_t q[$];
  vec_t vecs[18];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .f_valid_i       (f_valid_i),
    .f_ready_o       (f_ready_o),
    .f_pc_i          (f_pc_i),
    .f_pc_p4_i       (f_pc_p4_i),
    .f_instr_i       (f_instr_i),
    .f_pred_taken_i  (f_pred_taken_i),
    .f_pred_target_i (f_pred_target_i),
    .d_valid_o       (d_valid_o),
    .d_ready_i       (d_ready_i),
    .d_pc_o          (d_pc_o),
    .d_pc_p4_o       (d_pc_p4_o),
    .d_instr_o       (d_instr_o),
    .d_pred_taken_o  (d_pred_taken_o),
    .d_pred_target_o (d_pred_target_o),
    .count_o         (count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk_ent(input logic [31:0] pc);
    ent_t e;
    e.pc    = pc;
    e.pc_p4 = pc + 32'd4;
    e.instr = pc ^ 32'hA5A5_0013;
    e.pt    = pc[2];
    e.tgt   = pc + 32'h40;
    return e;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic fl, input logic fv, input ent_t e, input logic dr);
    @(posedge clk);
    #1;
    flush_i         = fl;
    f_valid_i       = fv;
    f_pc_i          = e.pc;
    f_pc_p4_i       = e.pc_p4;
    f_instr_i       = e.instr;
    f_pred_taken_i  = e.pt;
    f_pred_target_i = e.tgt;
    d_ready_i       = dr;
    @(negedge clk);
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, 1'b0, mk_ent(32'h0), dr);
  endtask

  initial begin
    ent_t e;
    ent_t exp_d;
    logic exp_dv;
    logic fl, fv, dr;

    // fill/drain then flush, one row per cycle, expectations sampled before the edge
    vecs[0]  = '{1'b0, 1'b1, 32'h0,   1'b0, 0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h4,   1'b0, 1, 1'b1, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h8,   1'b0, 2, 1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'hC,   1'b0, 3, 1'b1, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h10,  1'b0, 4, 1'b0, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 4, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 3, 1'b1, 1'b1, 32'h4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 2, 1'b1, 1'b1, 32'h8};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 1'b1, 32'hC};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h20,  1'b0, 0, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h24,  1'b0, 1, 1'b1, 1'b1, 32'h20};
    vecs[12] = '{1'b0, 1'b1, 32'h28,  1'b0, 2, 1'b1, 1'b1, 32'h20};
    vecs[13] = '{1'b1, 1'b1, 32'h100, 1'b1, 3, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 32'h200, 1'b1, 0, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1, 1'b1, 1'b1, 32'h200};
    vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 0, 1'b1, 1'b0, 32'h0};

    // Reset state, observed while reset is held
    #2;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_f_ready", 32'(f_ready_o), 32'd1);
    check("rst_d_valid", 32'(d_valid_o), 32'd0);
    check("rst_d_instr", d_instr_o, 32'd0);
    #6 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].flush, vecs[i].fv, mk_ent(vecs[i].pc), vecs[i].dr);
      check($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_f_ready", i), 32'(f_ready_o), 32'(vecs[i].frdy));
      check($sformatf("vec%0d_d_valid", i), 32'(d_valid_o), 32'(vecs[i].dv));
      check($sformatf("vec%0d_d_pc", i), d_pc_o, vecs[i].dpc);
    end

    // Streaming: one entry in flight, no bubbles
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, mk_ent(32'h1000 + 32'(4 * k)), 1'b1);
      if (k == 0) begin
        check("stream_first_d_valid", 32'(d_valid_o), 32'd0);
      end else begin
        check($sformatf("stream%0d_d_valid", k), 32'(d_valid_o), 32'd1);
        check($sformatf("stream%0d_count", k), 32'(count_o), 32'd1);
        check($sformatf("stream%0d_d_pc", k), d_pc_o, 32'h1000 + 32'(4 * (k - 1)));
      end
    end
    idle(1'b1);
    idle(1'b1);
    check("stream_drained", 32'(count_o), 32'd0);

    // Predictor fields travel with the entry
    e = mk_ent(32'h3000);
    e.pt  = 1'b1;
    e.tgt = 32'h80;
    drive(1'b0, 1'b1, e, 1'b0);
    idle(1'b1);
    check("pred_d_valid", 32'(d_valid_o), 32'd1);
    check("pred_taken", 32'(d_pred_taken_o), 32'd1);
    check("pred_target", d_pred_target_o, 32'h80);
    check("pred_pc_p4", d_pc_p4_o, 32'h3004);
    idle(1'b0);

    // Asynchronous reset mid-cycle with two entries queued
    drive(1'b0, 1'b1, mk_ent(32'h4000), 1'b0);
    drive(1'b0, 1'b1, mk_ent(32'h4004), 1'b0);
    idle(1'b0);
    check("arst_pre_count", 32'(count_o), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_d_valid", 32'(d_valid_o), 32'd0);
    check("arst_d_instr", d_instr_o, 32'd0);
    check("arst_f_ready", 32'(f_ready_o), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    e = mk_ent(32'h5000);
    e.instr = 32'h0000_0013;
    drive(1'b0, 1'b1, e, 1'b0);
    check("arst_after_push_d_valid", 32'(d_valid_o), 32'd0);
    idle(1'b1);
    check("arst_after_d_instr", d_instr_o, 32'h0000_0013);
    check("arst_after_count", 32'(count_o), 32'd1);
    idle(1'b0);

    // Randomized traffic against a queue model
    q.delete();
    for (int c = 0; c < 300; c++) begin
      fl = ($urandom_range(0, 24) == 0);
      fv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 1) == 1);
      e.pc    = $urandom;
      e.pc_p4 = $urandom;
      e.instr = $urandom;
      e.pt    = 1'($urandom);
      e.tgt   = $urandom;
      drive(fl, fv, e, dr);
      exp_dv = (q.size() != 0) && !fl;
      exp_d  = exp_dv ? q[0] : '0;
      check("rnd_count", 32'(count_o), 32'(q.size()));
      check("rnd_f_ready", 32'(f_ready_o), 32'(q.size() != DEPTH));
      check("rnd_d_valid", 32'(d_valid_o), 32'(exp_dv));
      check("rnd_d_pc", d_pc_o, exp_d.pc);
      check("rnd_d_pc_p4", d_pc_p4_o, exp_d.pc_p4);
      check("rnd_d_instr", d_instr_o, exp_d.instr);
      check("rnd_d_pred_taken", 32'(d_pred_taken_o), 32'(exp_d.pt));
      check("rnd_d_pred_target", d_pred_target_o, exp_d.tgt);
      if (fl) begin
        q.delete();
      end else begin
        logic can_push;
        can_push = fv && (q.size() < DEPTH);
        if (exp_dv && dr) void'(q.pop_front());
        if (can_push) q.push_back(e);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port flush_i, input, 1 bit: branch/CSR redirect; discards all queued entries.
REQ-005 SHALL have port f_valid_i, input, 1 bit: the fetch stage presents an entry this cycle.
REQ-006 SHALL have port f_ready_o, output, 1 bit: the queue can accept an entry; drives the fetch PC enable.
REQ-007 SHALL have ports f_pc_i, f_pc_p4_i, f_instr_i, f_pred_target_i, input, 32 bits each: fetched PC, PC+4, instruction word, predicted target.
REQ-008 SHALL have port f_pred_taken_i, input, 1 bit: predictor taken flag.
REQ-009 SHALL have port d_valid_o, output, 1 bit: the head entry is presented to decode.
REQ-010 SHALL have port d_ready_i, input, 1 bit: decode accepts the head entry.
REQ-011 SHALL have ports d_pc_o, d_pc_p4_o, d_instr_o, d_pred_target_o, output, 32 bits each; and d_pred_taken_o, output, 1 bit: head-entry fields.
REQ-012 SHALL have port count_o, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-013 The queue SHALL be a circular FIFO of DEPTH entries, each holding {pc, pc_p4, instr, pred_taken, pred_target} (129 bits).
REQ-014 Push SHALL occur when f_valid_i && f_ready_o && !flush_i; the entry is written at wr_ptr, and wr_ptr advances by 1 modulo DEPTH.
REQ-015 Pop SHALL occur when d_valid_o && d_ready_i; rd_ptr advances by 1 modulo DEPTH.
REQ-016 f_ready_o SHALL equal (count_o != DEPTH); it SHALL NOT depend combinationally on d_ready_i. When full, no push occurs in the same cycle as a pop.
REQ-017 d_valid_o SHALL equal (count_o != 0) && !flush_i.
REQ-018 The d_* data outputs SHALL show the entry at rd_ptr when d_valid_o=1, and SHALL be all-zero otherwise.
REQ-019 Latency SHALL be exactly one cycle: an entry pushed in cycle N appears at the head no earlier than cycle N+1. There SHALL be no combinational bypass from the f_* inputs to the d_* outputs.
REQ-020 count update:
- push only: +1
- pop only: -1
- simultaneous push and pop: unchanged
- neither: unchanged
REQ-021 Simultaneous push and pop with count_o=1 SHALL leave count_o=1, with the new entry at the head in the next cycle.
REQ-022 Pushes SHALL NOT be possible while count_o=DEPTH, and pops SHALL NOT be possible while count_o=0; the pointers and count SHALL never overflow or underflow.
REQ-023 flush_i=1 SHALL, at the next edge, set wr_ptr=0, rd_ptr=0 and count_o=0. The same-cycle push and pop are both suppressed. flush_i has priority over all other events.
REQ-024 Pointers SHALL be clog2(DEPTH) bits wide, and wrap from DEPTH-1 to 0 without a gap.
REQ-025 Entry order SHALL be strictly preserved: decode receives entries in push order, with no duplication and no loss except by flush.
REQ-026 Storage contents of freed entries SHALL NOT be observable at the outputs (see REQ-018).

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- wr_ptr=0, rd_ptr=0, count_o=0
- d_valid_o=0
- all d_* data outputs = 0
- f_ready_o=1
REQ-028 Storage SHALL be cleared to zero on reset.
REQ-029 Reset asserted mid-operation SHALL discard all entries. The first edge after deassertion SHALL accept a push normally.

Verification
REQ-030 Scenario "fill and drain": with d_ready_i=0, push pc=0x0,0x4,0x8,0xC -> after 4 pushes count_o=4 and f_ready_o=0; a 5th f_valid_i is ignored; then d_ready_i=1 -> d_pc_o sequence 0x0,0x4,0x8,0xC, then d_valid_o=0.
REQ-031 Scenario "streaming": f_valid_i=1 and d_ready_i=1 continuously from empty -> d_valid_o=1 from cycle 2 onward; count_o holds at 1; pc increments by 4 every cycle with no bubble.
REQ-032 Scenario "flush": with 3 entries queued, assert flush_i together with a push of pc=0x100 -> d_valid_o=0 during that cycle, count_o=0 in the next cycle, and 0x100 is never output.
REQ-033 Scenario "wrap-around": over DEPTH*3 push/pop cycles with random d_ready_i -> output order equals input order and count_o stays within 0..DEPTH.
REQ-034 Scenario "async reset": assert rst_n=0 mid-cycle with count_o=2 -> count_o=0, d_valid_o=0, d_instr_o=0 immediately; after release, push instr=0x00000013 -> d_instr_o=0x00000013 one cycle later.
REQ-035 Scenario "predictor fields": push pred_taken=1, pred_target=0x80 -> d_pred_taken_o=1 and d_pred_target_o=0x80 on the same cycle that the entry is at the head.
